pc_fetch_ctrl: RTL

- Upstream neighbour of the instruction ROM in the fetch stage.
- Owns the program counter and drives the ROM's chip-enable and fetch address (`pc_o`, `ce_o`).
- Handles stall hold, branch redirect, pipeline-flush redirect, and buffering of a branch that arrives while stalled.
- Flags misaligned fetch addresses for the exception logic.

---
 rtl/pc_fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Purpose:
//   Program-counter owner for the fetch stage. It sits directly upstream of
//   the instruction ROM and drives that ROM's fetch address and chip-enable.
//   It handles the following cases:
//     - stall hold
//     - branch redirect
//     - flush redirect for exceptions and eret
//     - buffering of one branch target that arrives while the stage is stalled
//   It also flags misaligned fetch addresses for the exception logic.
//
// Optional feature (macro PC_FETCH_CNT_EN):
//   When defined, fetch_cnt_o counts completed fetches. A fetch is completed
//   on any edge in S_RUN with no stall, no flush and no fetch error. The
//   counter wraps at 2^32 and is cleared by reset.
//   When undefined, fetch_cnt_o is tied to zero and no counter register is
//   built.
//
// Parameters:
//   RESET_PC  PC loaded by reset; this is always the first fetch address.
//   PC_STEP   Sequential increment in bytes.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   synchronous reset, active low
//   stall_i          in   1 = hold the PC
//   branch_flag_i    in   1 = taken branch/jump resolved in ID this cycle
//   branch_target_i  in   branch/jump target (valid with branch_flag_i)
//   flush_i          in   1 = redirect to new_pc_i (highest priority)
//   new_pc_i         in   exception handler / return address
//   pc_o             out  current fetch address (registered)
//   ce_o             out  ROM chip-enable (registered, 1 while running)
//   fetch_err_o      out  ce_o and pc_o not word aligned (combinational)
//   redirect_pend_o  out  a branch target is buffered behind a stall
//   fetch_cnt_o      out  completed-fetch counter (zero when feature off)
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        fetch_err_o,
  output logic        redirect_pend_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic {
    S_RST = 1'b0,
    S_RUN = 1'b1
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state_reg,       state_next;
  logic [31:0] pc_reg,          pc_next;
  logic        pend_valid_reg,  pend_valid_next;
  logic [31:0] pend_target_reg, pend_target_next;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= S_RST;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;

    case (state_reg)
      S_RST: begin
        // All pipeline inputs are ignored here.
        // This guarantees that the first fetch is RESET_PC.
        state_next = S_RUN;
      end

      S_RUN: begin
        if (flush_i) begin
          // A flush overrides everything, including a buffered branch.
          pc_next         = new_pc_i;
          pend_valid_next = 1'b0;
        end else if (stall_i) begin
          // Hold the PC.
          // A branch seen during the stall is parked until the stall releases.
          // A newer parked branch replaces an older one.
          if (branch_flag_i) begin
            pend_valid_next  = 1'b1;
            pend_target_next = branch_target_i;
          end
        end else if (branch_flag_i) begin
          // A live branch is newer than any buffered one, so it wins.
          pc_next         = branch_target_i;
          pend_valid_next = 1'b0;
        end else if (pend_valid_reg) begin
          pc_next         = pend_target_reg;
          pend_valid_next = 1'b0;
        end else begin
          // Natural 32-bit wrap, with no flag.
          pc_next = pc_reg + STEP;
        end
      end

      default: begin
        state_next = S_RST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_o            = pc_reg;
  assign ce_o            = (state_reg == S_RUN);
  assign redirect_pend_o = pend_valid_reg;

  // The PC is not corrected here.
  // The exception logic is expected to respond with a flush.
  assign fetch_err_o = ce_o & (pc_reg[1:0] != 2'b00);

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_reg <= 32'h0;
    end else if ((state_reg == S_RUN) && !stall_i && !flush_i && !fetch_err_o) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_reg;
`else
  assign fetch_cnt_o = 32'h0;
`endif

endmodule
